// File: rtl/gpp_pkg.sv
// gpp_pkg: shared definitions for the register-transfer control path.
// Holds the instruction opcode and operand-select encodings seen on the
// decode interface, and the sequencer state type.
package gpp_pkg;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDR = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_ALU = 3'd3;
  localparam logic [2:0] OP_STR = 3'd4;

  localparam logic SEL_X = 1'b0;
  localparam logic SEL_Y = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_REG    = 3'd1,
    S_MEM_WAIT  = 3'd2,
    S_ACC_WR    = 3'd3,
    S_ALU_START = 3'd4,
    S_ALU_WAIT  = 3'd5,
    S_ALU_SAVE  = 3'd6,
    S_ST_WAIT   = 3'd7
  } seq_state_t;

endpackage

// File: rtl/reg_access_sequencer_if.sv
// reg_access_sequencer_if: bundle of the sequencer's decode, register-bank,
// memory and ALU signals.
//   master : the sequencer (drives ready, strobes, requests, error pulses)
//   slave  : the surrounding decode / bank / memory / ALU side
interface reg_access_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic       instr_sel;
  logic       reg_write_x;
  logic       reg_write_y;
  logic       reg_write_accumulator;
  logic       reg_read_x;
  logic       reg_read_y;
  logic       signal_save_after_alu;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;
  logic       alu_start;
  logic       alu_done;
  logic       illegal_op;
  logic       timeout_err;

  modport master (
    input  instr_valid, instr_op, instr_sel, mem_ack, alu_done,
    output instr_ready, reg_write_x, reg_write_y, reg_write_accumulator,
           reg_read_x, reg_read_y, signal_save_after_alu,
           mem_req, mem_we, alu_start, illegal_op, timeout_err
  );

  modport slave (
    output instr_valid, instr_op, instr_sel, mem_ack, alu_done,
    input  instr_ready, reg_write_x, reg_write_y, reg_write_accumulator,
           reg_read_x, reg_read_y, signal_save_after_alu,
           mem_req, mem_we, alu_start, illegal_op, timeout_err
  );
endinterface

// File: rtl/reg_access_sequencer_handshake_timeout_counter.sv
// handshake_timeout_counter: 8-bit wait counter shared by all handshake
// wait states.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : synchronous clear (takes priority over enable)
//   enable   : count up by one
//   limit    : abort threshold in wait cycles (1..255)
//   expire   : this is the last permitted wait cycle; if the response is
//              still absent on this edge, the count would reach limit
module handshake_timeout_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expire
);
  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == (limit - 8'd1));
endmodule

// File: rtl/reg_access_sequencer.sv
// reg_access_sequencer: accepts one register-transfer instruction at a time
// and sequences register-bank strobes plus memory/ALU handshakes, aborting
// any handshake that exceeds TIMEOUT_CYCLES wait cycles.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : decode / bank / memory / ALU signals (master side)
module reg_access_sequencer
  import gpp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_access_sequencer_if.master bus
);
  seq_state_t state;
  logic [2:0] op_q;
  logic       sel_q;
  logic       illegal_q;
  logic       timeout_q;
  logic       in_wait;
  logic       resp;
  logic       expire;

  assign in_wait = (state == S_MEM_WAIT) || (state == S_ALU_WAIT) ||
                   (state == S_ST_WAIT);
  assign resp    = (state == S_ALU_WAIT) ? bus.alu_done : bus.mem_ack;

  // Holding the counter clear outside the wait states is equivalent to
  // clearing it on entry, since every wait state is entered from a non-wait one.
  handshake_timeout_counter u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait && !resp),
    .limit  (8'(TIMEOUT_CYCLES)),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      sel_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            op_q  <= bus.instr_op;
            sel_q <= bus.instr_sel;
            case (bus.instr_op)
              OP_NOP:  state <= S_IDLE;
              OP_LDR:  state <= S_WR_REG;
              OP_LDA:  state <= S_MEM_WAIT;
              OP_ALU:  state <= S_ALU_START;
              OP_STR:  state <= S_ST_WAIT;
              default: illegal_q <= 1'b1;
            endcase
          end
        end
        S_WR_REG:    state <= S_IDLE;
        S_ACC_WR:    state <= S_IDLE;
        S_ALU_START: state <= S_ALU_WAIT;
        S_ALU_SAVE:  state <= S_IDLE;
        S_MEM_WAIT: begin
          if (bus.mem_ack) begin
            state <= S_ACC_WR;
          end else if (expire) begin
            state     <= S_IDLE;
            timeout_q <= 1'b1;
          end
        end
        S_ALU_WAIT: begin
          if (bus.alu_done) begin
            state <= S_ALU_SAVE;
          end else if (expire) begin
            state     <= S_IDLE;
            timeout_q <= 1'b1;
          end
        end
        S_ST_WAIT: begin
          if (bus.mem_ack) begin
            state <= S_IDLE;
          end else if (expire) begin
            state     <= S_IDLE;
            timeout_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic rdy, wx, wy, wacc, rx, ry, save, mreq, mwe, astart;

  always_comb begin
    rdy    = 1'b0;
    wx     = 1'b0;
    wy     = 1'b0;
    wacc   = 1'b0;
    rx     = 1'b0;
    ry     = 1'b0;
    save   = 1'b0;
    mreq   = 1'b0;
    astart = 1'b0;
    case (state)
      S_IDLE:      rdy = 1'b1;
      S_WR_REG: begin
        wx = (sel_q == SEL_X);
        wy = (sel_q == SEL_Y);
      end
      S_MEM_WAIT:  mreq = 1'b1;
      S_ACC_WR:    wacc = 1'b1;
      S_ALU_START: begin
        rx     = (sel_q == SEL_X);
        ry     = (sel_q == SEL_Y);
        astart = 1'b1;
      end
      S_ALU_WAIT: begin
        rx = (sel_q == SEL_X);
        ry = (sel_q == SEL_Y);
      end
      S_ALU_SAVE: begin
        rx   = (sel_q == SEL_X);
        ry   = (sel_q == SEL_Y);
        save = 1'b1;
      end
      S_ST_WAIT: begin
        rx   = (sel_q == SEL_X);
        ry   = (sel_q == SEL_Y);
        mreq = 1'b1;
      end
      default: rdy = 1'b0;
    endcase
    // Only a store reaches a memory wait with a STR opcode latched.
    mwe = mreq && (op_q == OP_STR);
  end

  assign bus.instr_ready           = rdy;
  assign bus.reg_write_x           = wx;
  assign bus.reg_write_y           = wy;
  assign bus.reg_write_accumulator = wacc;
  assign bus.reg_read_x            = rx;
  assign bus.reg_read_y            = ry;
  assign bus.signal_save_after_alu = save;
  assign bus.mem_req               = mreq;
  assign bus.mem_we                = mwe;
  assign bus.alu_start             = astart;
  assign bus.illegal_op            = illegal_q;
  assign bus.timeout_err           = timeout_q;
endmodule

// File: tb/tb_reg_access_sequencer.sv
// tb_reg_access_sequencer: directed-vector bench with a transaction-level
// model that expands each accepted instruction into its expected per-cycle
// output vectors; one process compares DUT outputs against it every cycle.
module tb_reg_access_sequencer;
  import gpp_pkg::*;

  localparam int TO = 6;

  // output vector bit positions
  localparam int B_RDY = 11, B_WX = 10, B_WY = 9, B_WA = 8, B_RX = 7, B_RY = 6;
  localparam int B_SV = 5, B_MR = 4, B_MW = 3, B_AS = 2, B_IL = 1, B_TO = 0;
  localparam logic [11:0] IDLE_V = 12'h800;

  logic clk;
  logic rst;
  reg_access_sequencer_if bus ();

  reg_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stim_k = -1;
  logic [11:0] exp_q[$];

  int c_wx, c_wy, c_wa, c_rx, c_ry, c_sv, c_mr, c_mw, c_il, c_to;

  function automatic logic [11:0] m(int b);
    return 12'(1) << b;
  endfunction

  // Expected per-cycle outputs of one instruction, from the cycle after acceptance.
  function automatic void push_instr(logic [2:0] op, logic sel, int k);
    logic [11:0] rd;
    bit ok;
    int n;
    rd = sel ? m(B_RY) : m(B_RX);
    ok = (k >= 0) && (k < TO);
    n  = ok ? k + 1 : TO;
    case (op)
      OP_NOP: ;
      OP_LDR: exp_q.push_back(sel ? m(B_WY) : m(B_WX));
      OP_LDA: begin
        for (int i = 0; i < n; i++) exp_q.push_back(m(B_MR));
        exp_q.push_back(ok ? m(B_WA) : (IDLE_V | m(B_TO)));
      end
      OP_ALU: begin
        exp_q.push_back(rd | m(B_AS));
        for (int i = 0; i < n; i++) exp_q.push_back(rd);
        exp_q.push_back(ok ? (rd | m(B_SV)) : (IDLE_V | m(B_TO)));
      end
      OP_STR: begin
        for (int i = 0; i < n; i++) exp_q.push_back(rd | m(B_MR) | m(B_MW));
        if (!ok) exp_q.push_back(IDLE_V | m(B_TO));
      end
      default: exp_q.push_back(IDLE_V | m(B_IL));
    endcase
  endfunction

  // model advance
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
      end else begin
        bit ready;
        ready = (exp_q.size() == 0) || exp_q[0][B_RDY];
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (bus.instr_valid && ready) push_instr(bus.instr_op, bus.instr_sel, stim_k);
      end
    end
  end

  function automatic logic [11:0] got_vec();
    return {bus.instr_ready, bus.reg_write_x, bus.reg_write_y, bus.reg_write_accumulator,
            bus.reg_read_x, bus.reg_read_y, bus.signal_save_after_alu, bus.mem_req,
            bus.mem_we, bus.alu_start, bus.illegal_op, bus.timeout_err};
  endfunction

  // per-cycle compare and pulse counting
  always @(negedge clk) begin
    logic [11:0] e, g;
    e = (exp_q.size() > 0) ? exp_q[0] : IDLE_V;
    g = got_vec();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL outputs t=%0t got=%b exp=%b", $time, g, e);
    end
    c_wx += int'(g[B_WX]); c_wy += int'(g[B_WY]); c_wa += int'(g[B_WA]);
    c_rx += int'(g[B_RX]); c_ry += int'(g[B_RY]); c_sv += int'(g[B_SV]);
    c_mr += int'(g[B_MR]); c_mw += int'(g[B_MW]); c_il += int'(g[B_IL]);
    c_to += int'(g[B_TO]);
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clr_counts();
    c_wx = 0; c_wy = 0; c_wa = 0; c_rx = 0; c_ry = 0;
    c_sv = 0; c_mr = 0; c_mw = 0; c_il = 0; c_to = 0;
  endtask

  // Issue one instruction; response pulses after k wait cycles (k<0: never).
  // noise drives the non-awaited response (and alu_done during ALU_START).
  task automatic issue(input logic [2:0] op, input logic sel, input int k, input bit noise);
    int rc, len;
    bit r;
    clr_counts();
    rc  = (op == OP_ALU) ? k + 2 : k + 1;
    len = ((k >= 0) ? k : TO) + 5;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr_op = op; bus.instr_sel = sel; stim_k = k;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_sel = 1'b0;
      r = (k >= 0) && (c == rc);
      if (op == OP_ALU) begin
        bus.alu_done = r || (noise && c == 1);
        bus.mem_ack  = noise;
      end else begin
        bus.mem_ack  = r;
        bus.alu_done = noise;
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.alu_done = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_sel = 1'b0;
    bus.mem_ack = 1'b0; bus.alu_done = 1'b0;
    clr_counts();
    #12;
    chk("reset_vector", int'(got_vec()), int'(IDLE_V));
    #10 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    issue(OP_LDR, 1'b1, -1, 1'b0);
    chk("ldr_y_wy", c_wy, 1);
    chk("ldr_y_wx", c_wx, 0);

    issue(OP_LDR, 1'b0, -1, 1'b0);
    chk("ldr_x_wx", c_wx, 1);

    issue(OP_ALU, 1'b0, 3, 1'b0);
    chk("alu_x_read_cycles", c_rx, 6);
    chk("alu_x_save", c_sv, 1);
    chk("alu_x_ry", c_ry, 0);

    issue(OP_LDA, 1'b0, 5, 1'b0);
    chk("lda_k5_memreq", c_mr, 6);
    chk("lda_k5_memwe", c_mw, 0);
    chk("lda_k5_accwr", c_wa, 1);
    chk("lda_k5_timeout", c_to, 0);

    issue(OP_LDA, 1'b0, 0, 1'b0);
    chk("lda_k0_memreq", c_mr, 1);

    issue(OP_STR, 1'b1, -1, 1'b0);
    chk("str_to_memwe", c_mw, TO);
    chk("str_to_ry", c_ry, TO);
    chk("str_to_pulse", c_to, 1);

    issue(OP_STR, 1'b1, TO - 1, 1'b0);
    chk("str_limit_edge_timeout", c_to, 0);

    issue(OP_ALU, 1'b1, -1, 1'b0);
    chk("alu_to_pulse", c_to, 1);
    chk("alu_to_save", c_sv, 0);

    issue(OP_ALU, 1'b1, 0, 1'b1);
    chk("alu_noise_save", c_sv, 1);
    chk("alu_noise_ry", c_ry, 3);

    issue(OP_LDA, 1'b0, 2, 1'b1);
    chk("lda_noise_memreq", c_mr, 3);

    issue(3'd5, 1'b0, -1, 1'b0);
    issue(3'd7, 1'b1, -1, 1'b0);
    chk("illegal7_pulse", c_il, 1);

    // back-to-back illegal then NOP
    clr_counts();
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr_op = 3'd6; stim_k = -1;
    @(negedge clk);
    bus.instr_op = OP_NOP;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("b2b_illegal_pulse", c_il, 1);
    chk("b2b_no_strobes", c_wx + c_wy + c_wa + c_sv + c_mr, 0);

    // reset while waiting for alu_done
    clr_counts();
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr_op = OP_ALU; bus.instr_sel = 1'b0; stim_k = -1;
    @(negedge clk);
    bus.instr_valid = 1'b0; bus.instr_op = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("reset_mid_alu", int'(got_vec()), int'(IDLE_V));
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("reset_rx_cycles", c_rx, 3);
    chk("reset_no_save", c_sv, 0);

    issue(OP_LDR, 1'b1, -1, 1'b0);
    chk("post_reset_ldr", c_wy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
